regfile_scoreboard: RTL and testbench

Parametrised integer register file for the RISC-V core with a built-in scoreboard. It provides NRD combinational read ports with same-cycle writeback bypass, one clocked writeback port, and per-register busy tracking so the issue stage can detect RAW hazards (via `rd_busy`) and stall WAW conflicts (via `issue_ready`). Register x0 is hardwired to zero. The block sits between decode/issue and the writeback stage, replacing the flat two-read, one-write register file.

---
 rtl/regfile_scoreboard.sv | 113 +++++++++++
 tb/tb_regfile_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with NRD bypassed read ports, one writeback port and
// per-register busy tracking for RAW/WAW hazard detection at issue.
module regfile_scoreboard #(
   parameter  int XLEN  = 64,
   parameter  int NREGS = 32,
   parameter  int NRD   = 2,
   localparam int AW    = $clog2(NREGS),
   localparam int CW    = $clog2(NREGS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*XLEN-1:0]   rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  issue_valid,
   input  logic [AW-1:0]         issue_rd,
   output logic                  issue_ready,
   input  logic                  wb_valid,
   input  logic [AW-1:0]         wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   output logic [CW-1:0]         busy_count,
   output logic                  wb_orphan
);

   localparam logic [AW-1:0] X0 = {AW{1'b0}};

   logic [XLEN-1:0]  regs_r [1:NREGS-1];
   logic [NREGS-1:0] busy_r;
   logic [NREGS-1:0] busy_nxt_s;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_nxt_s;
   logic             orphan_r;
   logic             wb_hit_s;
   logic             issue_ready_s;
   logic             set_s;
   logic [AW-1:0]    addr_s;

   assign wb_hit_s      = wb_valid && (wb_rd != X0);
   // A writeback to the same register this cycle frees it for the next writer.
   assign issue_ready_s = (issue_rd == X0) || !busy_r[issue_rd] ||
                          (wb_valid && (wb_rd == issue_rd));
   assign set_s         = issue_valid && issue_ready_s && (issue_rd != X0);

   assign issue_ready = issue_ready_s;
   assign busy_count  = count_r;
   assign wb_orphan   = orphan_r;

   // Read ports: x0 reads zero, a same-cycle writeback is bypassed.
   always_comb begin
      rd_data = {(NRD*XLEN){1'b0}};
      rd_busy = {NRD{1'b0}};
      addr_s  = X0;
      for (int i = 0; i < NRD; i++) begin
         addr_s = rd_addr[i*AW +: AW];
         if (addr_s == X0) begin
            rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
            rd_busy[i]              = 1'b0;
         end else if (wb_valid && (wb_rd == addr_s)) begin
            rd_data[i*XLEN +: XLEN] = wb_data;
            rd_busy[i]              = 1'b0;
         end else begin
            rd_data[i*XLEN +: XLEN] = regs_r[addr_s];
            rd_busy[i]              = busy_r[addr_s];
         end
      end
   end

   // Next busy vector (a new reservation beats a same-register clear) and its population.
   always_comb begin
      busy_nxt_s  = busy_r;
      count_nxt_s = {CW{1'b0}};
      for (int k = 1; k < NREGS; k++) begin
         if (set_s && (issue_rd == AW'(k))) begin
            busy_nxt_s[k] = 1'b1;
         end else if (wb_hit_s && (wb_rd == AW'(k))) begin
            busy_nxt_s[k] = 1'b0;
         end else begin
            busy_nxt_s[k] = busy_r[k];
         end
      end
      busy_nxt_s[0] = 1'b0;
      for (int k = 1; k < NREGS; k++) begin
         count_nxt_s = count_nxt_s + CW'(busy_nxt_s[k]);
      end
   end

   // Register array storage; x0 has no storage and its writes are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k < NREGS; k++) begin
            regs_r[k] <= {XLEN{1'b0}};
         end
      end else if (wb_hit_s) begin
         regs_r[wb_rd] <= wb_data;
      end else begin
         regs_r[1] <= regs_r[1];
      end
   end

   // Scoreboard state: busy bits, busy population and sticky orphan flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r   <= {NREGS{1'b0}};
         count_r  <= {CW{1'b0}};
         orphan_r <= 1'b0;
      end else begin
         busy_r   <= busy_nxt_s;
         count_r  <= count_nxt_s;
         orphan_r <= orphan_r | (wb_hit_s && !busy_r[wb_rd]);
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table,
// mid-cycle reset sequences, then random traffic against a reference model.
module tb_regfile_scoreboard;

   localparam int XLEN  = 64;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;
   localparam int CW    = 6;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                issue_valid;
   logic [AW-1:0]       issue_rd;
   logic                issue_ready;
   logic                wb_valid;
   logic [AW-1:0]       wb_rd;
   logic [XLEN-1:0]     wb_data;
   logic [CW-1:0]       busy_count;
   logic                wb_orphan;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .busy_count(busy_count), .wb_orphan(wb_orphan)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [4:0]  ird;
      logic        wv;
      logic [4:0]  wrd;
      logic [63:0] wd;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [1:0]  busy;
      logic        ready;
      int          cnt;
      logic        orph;
   } vec_t;

   vec_t tbl [15];

   // reference model state
   logic [63:0] m_regs [32];
   bit          m_busy [32];
   bit          m_orphan;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [4:0] ird, input logic wv,
                        input logic [4:0] wrd, input logic [63:0] wd,
                        input logic [4:0] a0, input logic [4:0] a1);
      issue_valid = iv;
      issue_rd    = ird;
      wb_valid    = wv;
      wb_rd       = wrd;
      wb_data     = wd;
      rd_addr     = {a1, a0};
   endtask

   function automatic logic [63:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 64'd0;
      if (wb_valid && wb_rd == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic bit m_rbusy(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if (wb_valid && wb_rd == a) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic bit m_ready();
      return (issue_rd == 5'd0) || !m_busy[issue_rd] || (wb_valid && wb_rd == issue_rd);
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int k = 1; k < 32; k++) c += int'(m_busy[k]);
      return c;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 32; k++) begin
         m_regs[k] = 64'd0;
         m_busy[k] = 1'b0;
      end
      m_orphan = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 5'd2, 1'b0, 5'd0, 64'd0,  5'd1, 5'd2, 64'd0,  64'd0,  2'b00, 1'b1, 0, 1'b0};
      tbl[1]  = '{1'b1, 5'd2, 1'b0, 5'd0, 64'd0,  5'd1, 5'd2, 64'd0,  64'd0,  2'b00, 1'b1, 1, 1'b0};
      tbl[2]  = '{1'b1, 5'd2, 1'b0, 5'd0, 64'd0,  5'd1, 5'd2, 64'd0,  64'd0,  2'b10, 1'b0, 1, 1'b0};
      tbl[3]  = '{1'b0, 5'd2, 1'b1, 5'd2, 64'd5,  5'd1, 5'd2, 64'd0,  64'd5,  2'b00, 1'b1, 0, 1'b0};
      tbl[4]  = '{1'b0, 5'd2, 1'b0, 5'd0, 64'd0,  5'd2, 5'd1, 64'd5,  64'd0,  2'b00, 1'b1, 0, 1'b0};
      tbl[5]  = '{1'b1, 5'd0, 1'b1, 5'd0, 64'd7,  5'd0, 5'd2, 64'd0,  64'd5,  2'b00, 1'b1, 0, 1'b0};
      tbl[6]  = '{1'b1, 5'd3, 1'b0, 5'd0, 64'd0,  5'd3, 5'd0, 64'd0,  64'd0,  2'b00, 1'b1, 1, 1'b0};
      tbl[7]  = '{1'b1, 5'd3, 1'b1, 5'd3, 64'd9,  5'd3, 5'd1, 64'd9,  64'd0,  2'b00, 1'b1, 1, 1'b0};
      tbl[8]  = '{1'b0, 5'd0, 1'b0, 5'd0, 64'd0,  5'd3, 5'd1, 64'd9,  64'd0,  2'b01, 1'b1, 1, 1'b0};
      tbl[9]  = '{1'b0, 5'd0, 1'b1, 5'd4, 64'd4,  5'd4, 5'd3, 64'd4,  64'd9,  2'b10, 1'b1, 1, 1'b1};
      tbl[10] = '{1'b0, 5'd0, 1'b0, 5'd0, 64'd0,  5'd4, 5'd3, 64'd4,  64'd9,  2'b10, 1'b1, 1, 1'b1};
      tbl[11] = '{1'b0, 5'd0, 1'b1, 5'd3, 64'd11, 5'd3, 5'd4, 64'd11, 64'd4,  2'b00, 1'b1, 0, 1'b1};
      tbl[12] = '{1'b1, 5'd1, 1'b0, 5'd0, 64'd0,  5'd1, 5'd5, 64'd0,  64'd0,  2'b00, 1'b1, 1, 1'b1};
      tbl[13] = '{1'b1, 5'd5, 1'b0, 5'd0, 64'd0,  5'd1, 5'd5, 64'd0,  64'd0,  2'b01, 1'b1, 2, 1'b1};
      tbl[14] = '{1'b1, 5'd7, 1'b0, 5'd0, 64'd0,  5'd7, 5'd5, 64'd0,  64'd0,  2'b10, 1'b1, 3, 1'b1};

      drive(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // directed vector table
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].iv, tbl[i].ird, tbl[i].wv, tbl[i].wrd, tbl[i].wd, tbl[i].a0, tbl[i].a1);
         #2;
         chk($sformatf("v%0d_d0", i), rd_data[63:0], tbl[i].d0);
         chk($sformatf("v%0d_d1", i), rd_data[127:64], tbl[i].d1);
         chk($sformatf("v%0d_busy", i), 64'(rd_busy), 64'(tbl[i].busy));
         chk($sformatf("v%0d_ready", i), 64'(issue_ready), 64'(tbl[i].ready));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_count", i), 64'(busy_count), 64'(tbl[i].cnt));
         chk($sformatf("v%0d_orphan", i), 64'(wb_orphan), 64'(tbl[i].orph));
      end

      // mid-cycle reset with x1, x5, x7 busy: outputs return at once
      drive(1'b0, 5'd1, 1'b0, 5'd0, 64'd0, 5'd1, 5'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 64'(rd_busy), 64'd0);
      chk("rst_count", 64'(busy_count), 64'd0);
      chk("rst_orphan", 64'(wb_orphan), 64'd0);
      chk("rst_ready", 64'(issue_ready), 64'd1);
      drive(1'b0, 5'd1, 1'b0, 5'd0, 64'd0, 5'd3, 5'd4);
      #1;
      chk("rst_x3", rd_data[63:0], 64'd0);
      chk("rst_x4", rd_data[127:64], 64'd0);

      // traffic during reset is discarded
      drive(1'b1, 5'd6, 1'b1, 5'd6, 64'd3, 5'd1, 5'd2);
      @(posedge clk);
      #1;
      chk("rstflight_count", 64'(busy_count), 64'd0);
      chk("rstflight_orphan", 64'(wb_orphan), 64'd0);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 5'd6, 5'd1);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rstflight_x6", rd_data[63:0], 64'd0);
      chk("rstflight_busy", 64'(rd_busy), 64'd0);
      chk("rstflight_count2", 64'(busy_count), 64'd0);

      // random traffic against the reference model
      m_reset();
      for (int n = 0; n < 400; n++) begin
         logic        iv, wv;
         logic [4:0]  ird, wrd, a0, a1;
         logic [63:0] wd;
         int          bl [$];
         bit          exp_ready;
         for (int k = 1; k < 8; k++) if (m_busy[k]) bl.push_back(k);
         iv  = ($urandom_range(0, 9) < 6);
         ird = 5'($urandom_range(0, 7));
         wv  = ($urandom_range(0, 1) == 1);
         if (bl.size() > 0 && $urandom_range(0, 9) < 7)
            wrd = 5'(bl[$urandom_range(0, bl.size() - 1)]);
         else
            wrd = 5'($urandom_range(0, 7));
         wd  = {$urandom, $urandom};
         a0  = ($urandom_range(0, 9) < 3) ? wrd : 5'($urandom_range(0, 7));
         a1  = 5'($urandom_range(0, 7));
         drive(iv, ird, wv, wrd, wd, a0, a1);
         #2;
         exp_ready = m_ready();
         chk("rnd_d0", rd_data[63:0], m_read(a0));
         chk("rnd_d1", rd_data[127:64], m_read(a1));
         chk("rnd_busy", 64'(rd_busy), 64'({m_rbusy(a1), m_rbusy(a0)}));
         chk("rnd_ready", 64'(issue_ready), 64'(exp_ready));
         @(posedge clk);
         if (wv && wrd != 5'd0) begin
            if (!m_busy[wrd]) m_orphan = 1'b1;
            m_regs[wrd] = wd;
            m_busy[wrd] = 1'b0;
         end
         if (iv && exp_ready && ird != 5'd0) m_busy[ird] = 1'b1;
         #1;
         chk("rnd_count", 64'(busy_count), 64'(m_count()));
         chk("rnd_orphan", 64'(wb_orphan), 64'(m_orphan));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
